// File: rtl/chacha_pkg.sv
// Shared widths, state encodings and ChaCha round helpers for the stream XOR engine.
package chacha_pkg;

    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = 512;
    localparam int WORDS_PER_BLOCK = 16;

    // Word i of a block lives at packed index i.
    typedef logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0] block_t;

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} main_state_t;
    typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT} fetch_state_t;

    // "expand 32-byte k", word 0 in the low bits.
    localparam logic [127:0] SIGMA = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic block_t qr(input block_t s, input int a, input int b, input int c, input int d);
        block_t x;
        x = s;
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 16);
        x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 12);
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 8);
        x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 7);
        return x;
    endfunction

    function automatic block_t double_round(input block_t s);
        block_t x;
        x = s;
        x = qr(x, 0, 4,  8, 12);
        x = qr(x, 1, 5,  9, 13);
        x = qr(x, 2, 6, 10, 14);
        x = qr(x, 3, 7, 11, 15);
        x = qr(x, 0, 5, 10, 15);
        x = qr(x, 1, 6, 11, 12);
        x = qr(x, 2, 7,  8, 13);
        x = qr(x, 3, 4,  9, 14);
        return x;
    endfunction

endpackage

// File: rtl/chacha.sv
// Iterative ChaCha20 keystream core: one double round per cycle, Done after 10 cycles.
// stream presents the keystream as a byte stream, first byte in bits [511:504].
module chacha
    import chacha_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset,
    input  logic [255:0]       key,
    input  logic [127:0]       nonce,
    output logic               Done,
    output logic [BLOCK_W-1:0] stream
);

    block_t     init_c;
    block_t     init_s;
    block_t     x_s;
    block_t     stream_w;
    logic [3:0] rnd;

    assign init_c = {nonce, key, SIGMA};
    assign Done   = (rnd == 4'd10);
    assign stream = stream_w;

    // Reset loads the initial state; afterwards run the ten double rounds and hold.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            init_s <= init_c;
            x_s    <= init_c;
            rnd    <= '0;
        end else if (rnd != 4'd10) begin
            x_s <= double_round(x_s);
            rnd <= rnd + 4'd1;
        end
    end

    // Feed-forward add and little-endian serialisation, word 0 at the top.
    always_comb begin
        stream_w = '0;
        for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
            stream_w[WORDS_PER_BLOCK-1-i] = bswap32(x_s[i] + init_s[i]);
        end
    end

endmodule

// File: rtl/chacha_stream_xor.sv
// Streaming ChaCha20 XOR engine: drives the keystream core, double-buffers
// keystream blocks and XORs them into a 32-bit valid/ready stream.
module chacha_stream_xor
    import chacha_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic [255:0]      key,
    input  logic [95:0]       iv,
    input  logic [31:0]       ctr_init,
    input  logic              start,
    output logic              busy,
    output logic              ctr_wrap,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last
);

    main_state_t        state;
    fetch_state_t       fstate;
    logic [255:0]       key_r;
    logic [95:0]        iv_r;
    logic [31:0]        ctr;
    block_t             cur;
    block_t             nxt;
    logic               cur_valid;
    logic               nxt_valid;
    logic [3:0]         idx;
    logic [3:0]         widx;
    logic [WORD_W-1:0]  kword;
    logic               core_restart;
    logic               core_rst;
    logic               core_done;
    logic [BLOCK_W-1:0] core_stream;
    logic               start_acc;
    logic               accept;
    logic               last_acc;
    logic               wrap_acc;
    logic               cur_gone;
    logic               fetch_en;
    logic               buf_free;
    logic               fetch_cap;

    assign core_restart = (fstate == F_REQ);
    assign core_rst     = Reset | core_restart;
    assign busy         = (state != IDLE);
    assign start_acc    = start & (state == IDLE);
    assign in_ready     = (state == RUN) & cur_valid & (~out_valid | out_ready);
    assign accept       = in_valid & in_ready;
    assign last_acc     = accept & in_last;
    assign wrap_acc     = accept & ~in_last & (idx == 4'd15);
    // Last word of cur consumed with no prefetched block to swap in.
    assign cur_gone     = wrap_acc & ~nxt_valid;
    assign fetch_en     = (state == PRIME) | (state == RUN);
    assign buf_free     = ~cur_valid | ~nxt_valid;
    // A last-word acceptance in the same cycle drops the finished block.
    assign fetch_cap    = (fstate == F_WAIT) & core_done & ~last_acc;
    assign widx         = 4'(WORDS_PER_BLOCK - 1) - idx;
    assign kword        = cur[widx];

    chacha u_core (
        .Clk    (Clk),
        .Reset  (core_rst),
        .key    (key_r),
        .nonce  ({iv_r, ctr}),
        .Done   (core_done),
        .stream (core_stream)
    );

    // Main FSM: configuration capture and the stream lifetime.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            key_r <= '0;
            iv_r  <= '0;
        end else begin
            case (state)
                IDLE:    if (start) begin
                             state <= PRIME;
                             key_r <= key;
                             iv_r  <= iv;
                         end
                PRIME:   if (cur_valid) state <= RUN;
                RUN:     if (last_acc) state <= DRAIN;
                DRAIN:   if (!out_valid || out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Fetch FSM: restart the core for each block and advance the block counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fstate   <= F_IDLE;
            ctr      <= '0;
            ctr_wrap <= 1'b0;
        end else if (start_acc) begin
            fstate   <= F_IDLE;
            ctr      <= ctr_init;
            ctr_wrap <= 1'b0;
        end else begin
            case (fstate)
                F_IDLE:  if (fetch_en && buf_free && !last_acc) fstate <= F_REQ;
                F_REQ:   fstate <= last_acc ? F_IDLE : F_WAIT;
                F_WAIT:  if (last_acc) begin
                             fstate <= F_IDLE;
                         end else if (core_done) begin
                             fstate <= F_IDLE;
                             ctr    <= ctr + 32'd1;
                             if (ctr == 32'hFFFF_FFFF) ctr_wrap <= 1'b1;
                         end
                default: fstate <= F_IDLE;
            endcase
        end
    end

    // Keystream buffers, word index and the registered XOR output.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cur       <= '0;
            nxt       <= '0;
            cur_valid <= 1'b0;
            nxt_valid <= 1'b0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (accept) begin
                out_data  <= in_data ^ kword;
                out_last  <= in_last;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (last_acc) begin
                cur_valid <= 1'b0;
                nxt_valid <= 1'b0;
                idx       <= '0;
            end else begin
                if (accept) idx <= idx + 4'd1;
                if (wrap_acc && nxt_valid) begin
                    cur       <= nxt;
                    nxt_valid <= 1'b0;
                end
                // A fetch landing on a swap writes nxt, which the swap just freed.
                if (fetch_cap) begin
                    if (!cur_valid || cur_gone) begin
                        cur       <= core_stream;
                        cur_valid <= 1'b1;
                    end else begin
                        nxt       <= core_stream;
                        nxt_valid <= 1'b1;
                    end
                end else if (cur_gone) begin
                    cur_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_chacha_stream_xor.sv
// Scoreboard bench for chacha_stream_xor using RFC 8439 zero-key keystream words.
module tb_chacha_stream_xor;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic [255:0] key = '0;
    logic [95:0]  iv = '0;
    logic [31:0]  ctr_init = '0;
    logic         start = 1'b0;
    logic         busy;
    logic         ctr_wrap;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = '0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [31:0]  out_data;
    logic         out_last;

    typedef struct {
        logic [31:0] data;
        logic        last;
        bit          chk;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] obs_q[$];
    int          hs_q[$];
    int          asserts = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          rand_ready = 0;
    bit          gap = 0;
    bit          hold_v = 0;
    logic [31:0] hold_d;
    logic        hold_l;
    logic [31:0] pt[20];
    logic [31:0] ct[20];

    always #5 Clk = ~Clk;

    chacha_stream_xor dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .key       (key),
        .iv        (iv),
        .ctr_init  (ctr_init),
        .start     (start),
        .busy      (busy),
        .ctr_wrap  (ctr_wrap),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    // Known keystream words: block 0 words 0, 1, 15 and block 1 word 0.
    function automatic logic [31:0] ks(input int i);
        case (i)
            0:       return 32'h76b8e0ad;
            1:       return 32'ha0f13d90;
            15:      return 32'hb2ee6586;
            16:      return 32'h9f07e7be;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit known(input int i);
        return (i == 0) || (i == 1) || (i == 15) || (i == 16);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(posedge Clk) begin
        #1;
        out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // Monitor: hold stability and scoreboard pops on each output handshake.
    always @(negedge Clk) begin
        cyc++;
        if (Reset) begin
            hold_v = 0;
        end else begin
            if (hold_v) begin
                check("hold_valid", {31'b0, out_valid}, 32'd1);
                check("hold_data", out_data, hold_d);
                check("hold_last", {31'b0, out_last}, {31'b0, hold_l});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    asserts++;
                    errors++;
                    $display("FAIL unexpected_out: got %h with nothing expected", out_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_last", {31'b0, out_last}, {31'b0, e.last});
                    if (e.chk) check("out_data", out_data, e.data);
                end
                obs_q.push_back(out_data);
                hs_q.push_back(cyc);
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            hold_l = out_last;
        end
    end

    task automatic do_start(input logic [31:0] ci);
        key = '0;
        iv = '0;
        ctr_init = ci;
        start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic l, input logic [31:0] e, input bit c);
        exp_t t;
        int   n;
        int   g;
        g = gap ? int'($urandom_range(0, 2)) : 0;
        repeat (g) begin @(posedge Clk); #1; end
        t.data = e;
        t.last = l;
        t.chk  = c;
        exp_q.push_back(t);
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge Clk);
            if (in_ready === 1'b1) break;
            n++;
            if (n > 300) break;
        end
        check("in_accept_timeout", {31'b0, (n > 300)}, 32'd0);
        @(posedge Clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < limit) begin
            @(posedge Clk); #1;
            n++;
        end
        check("busy_fall", {31'b0, busy}, 32'd0);
        check("sb_drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_ctr_wrap", {31'b0, ctr_wrap}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_last", {31'b0, out_last}, 32'd0);
    endtask

    initial begin
        int n;
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge Clk);
        #1;
        check_reset_outputs();
        Reset = 1'b0;
        @(posedge Clk); #1;

        // Block 0 then block 1 back to back; a second start while busy is ignored.
        do_start(32'd0);
        check("busy_after_start", {31'b0, busy}, 32'd1);
        ctr_init = 32'd7;
        start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        check("busy_ignored_start", {31'b0, busy}, 32'd1);
        hs_q.delete();
        for (int i = 0; i < 17; i++) send(32'd0, (i == 16), ks(i), known(i));
        wait_idle(100);
        if (hs_q.size() >= 17) check("no_bubbles", 32'(hs_q[16] - hs_q[0]), 32'd16);
        else check("hs_count", 32'(hs_q.size()), 32'd17);

        // Encrypt 20 words, then decrypt them under backpressure and gaps.
        for (int i = 0; i < 20; i++) pt[i] = $urandom;
        obs_q.delete();
        do_start(32'd0);
        for (int i = 0; i < 20; i++) send(pt[i], (i == 19), pt[i] ^ ks(i), known(i));
        wait_idle(100);
        for (int i = 0; i < 20; i++) ct[i] = (i < obs_q.size()) ? obs_q[i] : 32'd0;
        rand_ready = 1;
        gap = 1;
        do_start(32'd0);
        for (int i = 0; i < 20; i++) send(ct[i], (i == 19), pt[i], 1);
        wait_idle(500);
        rand_ready = 0;
        gap = 0;

        // Counter wrap: second block uses counter 0.
        do_start(32'hFFFF_FFFF);
        for (int i = 0; i < 17; i++) send(32'd0, (i == 16), (i == 16) ? 32'h76b8e0ad : 32'd0, (i == 16));
        wait_idle(100);
        check("ctr_wrap_set", {31'b0, ctr_wrap}, 32'd1);

        // Reset in the middle of a block, then a clean restart.
        do_start(32'd0);
        check("ctr_wrap_cleared", {31'b0, ctr_wrap}, 32'd0);
        for (int i = 0; i < 7; i++) send(32'd0, 1'b0, ks(i), known(i));
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge Clk); #1;
            n++;
        end
        check("pre_reset_drain", 32'(exp_q.size()), 32'd0);
        Reset = 1'b1;
        in_valid = 1'b1;
        in_data = 32'd0;
        @(posedge Clk); #1;
        check_reset_outputs();
        @(posedge Clk); #1;
        Reset = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        do_start(32'd0);
        send(32'd0, 1'b0, 32'h76b8e0ad, 1);
        send(32'd0, 1'b1, 32'ha0f13d90, 1);
        wait_idle(100);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
        $finish;
    end

endmodule

// File: doc/chacha_stream_xor.md
# chacha_stream_xor

Streaming ChaCha20 encrypt/decrypt engine. It is the consumer end of the `chacha` keystream core and drives the core's `key`/`nonce`/`Reset` inputs. On `Done`, it captures the core's 512-bit `stream` and XORs it word-by-word into a 32-bit valid/ready data path. One keystream block is prefetched so that throughput is one word per cycle across block boundaries.

## Interface
Parameters: none. Constants are in `chacha_pkg`.

Ports:
- `Clk` in 1: system clock. One clock domain; rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `key` in 256: cipher key. Sampled on `start`.
- `iv` in 96: nonce. Sampled on `start`.
- `ctr_init` in 32: initial block counter. Sampled on `start`.
- `start` in 1: one-cycle pulse that loads the configuration and begins priming. Ignored unless `busy`=0.
- `busy` out 1: high from the accepted `start` until the last word has left the output.
- `ctr_wrap` out 1: sticky flag. Set when the block counter wraps from 32'hFFFFFFFF to 0. Cleared on `start` or `Reset`.
- `in_valid` in 1, `in_ready` out 1, `in_data` in 32, `in_last` in 1: plaintext or ciphertext input stream.
- `out_valid` out 1, `out_ready` in 1, `out_data` out 32, `out_last` out 1: XORed output stream.

## Operation
Core driving:
- Core nonce = {iv, ctr}. `ctr` occupies bits [31:0], which is state word 12.
- Core `Reset` = `Reset` | `core_restart`. `core_restart` is a one-cycle pulse issued by the fetch FSM.

Fetch FSM:
- F_IDLE -> F_REQ when a buffer is free.
- F_REQ: pulse `core_restart` with key/nonce stable; go to F_WAIT.
- F_WAIT: wait for core `Done`=1, sampled no earlier than the cycle after the pulse. Capture `stream` into the free buffer, increment `ctr` (mod 2^32, setting `ctr_wrap` on wrap), then go to F_IDLE.

Buffers:
- `cur` (active) and `nxt` (prefetch), each 512 bits plus a valid bit.
- A fetch fills `cur` if `cur` is empty, otherwise it fills `nxt`.

Main FSM:
- IDLE -> PRIME on `start`.
- PRIME -> RUN when `cur` is valid.
- RUN -> DRAIN when a word with `in_last`=1 is accepted.
- DRAIN -> IDLE when `out_valid`=0 or (`out_valid` & `out_ready`).

Data path:
- Keystream word `k` = `cur[511-32*idx -: 32]`, where `idx` is 0..15.
- `in_ready` = (state==RUN) & `cur_valid` & (!`out_valid` | `out_ready`).
- On accept: `out_data` <= `in_data` ^ k, `out_last` <= `in_last`, `out_valid` <= 1, `idx` <= `idx`+1.
- When `idx`==15 is accepted: `idx` <= 0. If `nxt_valid`, `cur` <= `nxt` in the same cycle and `nxt_valid` <= 0; otherwise `cur_valid` <= 0 and input stalls until the fetch completes.
- Acceptance of `in_last` discards remaining keystream words, `nxt`, and any in-flight fetch (fetch FSM -> F_IDLE). Any later `core_Done` is ignored.

Boundary conditions:
- Input arriving while output is full: stall, no data loss.
- Fetch completing in the same cycle as a swap: it writes `nxt`, which the swap has just freed.
- `start` while busy: ignored, no state change.
- `Reset` mid-operation: all state is returned to reset values immediately and buffers are invalidated.

## Timing
- Reset values: `busy`=0, `ctr_wrap`=0, `in_ready`=0, `out_valid`=0, `out_data`=0, `out_last`=0. Internally, `idx`=0, both buffer valid bits 0, FSMs at IDLE/F_IDLE.
- Word latency: 1 cycle from an `in_valid&in_ready` edge to `out_valid`.
- First-word latency after `start`: core latency + 3 cycles (F_REQ, capture, PRIME->RUN).
- Steady state: 1 word/cycle when core latency ≤ 15 cycles.
- `out_data`/`out_last` hold stable while `out_valid` & !`out_ready`.

## Structure
- `chacha_pkg` holds:
  - `WORD_W`=32, `BLOCK_W`=512, `WORDS_PER_BLOCK`=16.
  - `main_state_t` {IDLE, PRIME, RUN, DRAIN}.
  - `fetch_state_t` {F_IDLE, F_REQ, F_WAIT}.
- One sub-module instance: the existing `chacha` core, instantiated as `u_core`.
- Buffers, FSMs and the XOR path live in `chacha_stream_xor`. No further sub-modules.

## Test plan
- Key=0, iv=0, ctr_init=0, `start`, 16 zero input words, `out_ready`=1: first `out_data`=32'h76b8e0ad, word 15=32'hb2ee6586, no bubbles after the first word.
- Same config, 17 zero words with `in_last` on word 17: word 17 = 32'h9f07e7be (block counter 1), `out_last`=1 on it, then `busy` falls.
- Encrypt 20 random words, then restart with the same config and feed the ciphertext: the output equals the original plaintext.
- `out_ready` toggled pseudo-randomly and `in_valid` gapped: no word is lost or duplicated, and held outputs stay stable.
- ctr_init=32'hFFFFFFFF, 17 words: `ctr_wrap` rises after the first fetch, and the second block uses counter 0, matching the ctr_init=0 block-0 keystream.
- `Reset` asserted mid-block (word 7), then a new `start` with the same config: the output restarts at 32'h76b8e0ad, with all outputs at reset values during reset.
